parity_burst_arbiter: RTL and testbench
=======================================

Name: parity_burst_arbiter

Overview:
- Shares one step-by-2 parity counter between two requesters: an even-stream requester (index 0) and an odd-stream requester (index 1).
- Round-robin arbitration between them.
- Each grant seeds the counter with the winner's parity (0 or 1) and streams a burst of len values stepping by 2.
- Sits between stream consumers and the counter datapath, acting as its sequencer.

Parameters:
WIDTH, 4, counter/value width; arithmetic modulo 2^WIDTH
LEN_W, 4, burst-length field width

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-low
req  input  2  request; bit0 even requester, bit1 odd requester; must be held for the whole burst
len0  input  LEN_W  burst length for requester 0, sampled at grant
len1  input  LEN_W  burst length for requester 1, sampled at grant
gnt  output  2  one-hot grant, registered; 00 when idle
out_valid  output  1  beat valid
out_value  output  WIDTH  current counter value
out_last  output  1  high with the final beat of a burst
done  output  2  one-cycle pulse to the served requester after a burst completes
abort  output  1  one-cycle pulse after a burst is aborted

Behaviour:
- Reset (rst==0 at an edge):
  - state IDLE; gnt=00, out_valid=0, out_value=0, out_last=0, done=00, abort=0; remaining=0.
  - Round-robin pointer set so requester 0 wins the first tie.
  - Reset overrides everything, including mid-burst (no done/abort pulse).
- States:
  - IDLE: out_valid=0, gnt=00.
  - RUN: out_valid=1; gnt = served requester.
- IDLE -> RUN, at an edge where req!=00:
  - Winner: the sole requester, or on 11 the one not served last.
  - Load counter with 0 (winner 0) or 1 (winner 1).
  - remaining = winner's len; len==0 treated as 1.
  - Set gnt.
  - First beat is visible in the cycle after that edge (latency 1 from request sample).
- RUN, per edge, priority order:
  - If req[served]==0: abort. Go to IDLE, gnt=00, abort=1 next cycle, no done. The beat shown that cycle counts as not consumed.
  - Else if remaining==1: completion. Go to IDLE, gnt=00, done[served]=1 next cycle.
  - Else: counter += 2 (wraps modulo 2^WIDTH, parity preserved, e.g. 14->0, 15->1); remaining -= 1.
- out_last = (state==RUN && remaining==1); decoded from registers.
- On abort or completion, the pointer records the served requester.
- The IDLE cycle after a burst always arbitrates; minimum one idle cycle between bursts.
- Requests arriving during RUN wait; no preemption.
- len inputs are ignored except at the grant edge.
- done and abort are mutually exclusive; each is exactly one cycle wide.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, RUN)
  - requester index constants REQ_EVEN=0, REQ_ODD=1
  - STEP=2
  - seed values EVEN_SEED=0, ODD_SEED=1
- One sub-module, parity_step_counter (clk, rst, load, seed, en, count): synchronous active-low reset to 0; load has priority over en; en adds STEP.
- Arbiter, FSM and remaining counter live in the top level.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with req=11 -> gnt=00, out_valid=0, out_value=0, done=00, abort=0; first grant after release goes to requester 0.
2. Even burst: req=01, len0=4 -> beats 0,2,4,6 on consecutive cycles; out_last only on 6; then gnt=00 and done=01 for one cycle.
3. Odd burst:
   - req=10, len1=3 -> beats 1,3,5; done=10.
   - len1=0 -> single beat 1, with out_last set on it.
4. Round-robin: req=11 held, len0=len1=2 -> 0,2 (gnt=01); idle cycle; 1,3 (gnt=10); idle cycle; 0,2 (gnt=01).
5. Wrap:
   - len0=10 -> 0,2,...,14,0,2.
   - len1=9 -> 1,3,...,15,1.
   - out_value never changes parity.
6. Abort and reset mid-burst:
   - req=01, len0=5; drop req0 during the 3rd beat (value 4) -> abort=1 next cycle, done stays 00; a pending req1 is granted next, beats start at 1.
   - Separately, rst=0 during a burst -> all outputs 0 the next cycle, no pulses.

Source files
------------

// File: rtl/parity_burst_arbiter_pkg.sv
// Shared definitions for the parity burst arbiter: state encoding, requester
// indices, counter step and per-requester seeds.
package parity_burst_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned REQ_EVEN  = 0;
  localparam int unsigned REQ_ODD   = 1;
  localparam int unsigned STEP      = 2;
  localparam int unsigned EVEN_SEED = 0;
  localparam int unsigned ODD_SEED  = 1;

  // Sole requester wins; on a tie the one not served last wins.
  function automatic logic pick_winner(input logic [1:0] req, input logic last_served);
    logic w;
    case (req)
      2'b01:   w = 1'(REQ_EVEN);
      2'b10:   w = 1'(REQ_ODD);
      2'b11:   w = ~last_served;
      default: w = 1'(REQ_EVEN);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/parity_burst_arbiter_step_counter.sv
// Shared value counter: loads a parity seed, then advances by STEP so the
// seed's parity is preserved through wrap-around.
module parity_step_counter
  import parity_burst_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = seed;
    end else if (en) begin
      count_d = count_q + WIDTH'(STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/parity_burst_arbiter.sv
// Round-robin sequencer sharing one parity step counter between an even-stream
// and an odd-stream requester; each grant streams a burst of len beats.
//
//   state   | meaning
//   IDLE    | no burst active; arbitrates on every edge
//   RUN     | streaming beats for the served requester
module parity_burst_arbiter
  import parity_burst_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_value,
  output logic             out_last,
  output logic [1:0]       done,
  output logic             abort
);

  state_e           state_q, state_d;
  logic             served_q, served_d;
  logic             last_q, last_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             abort_q, abort_d;

  logic             winner;
  logic [LEN_W-1:0] winner_len;
  logic             cnt_load;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_seed;
  logic [WIDTH-1:0] cnt_value;

  parity_step_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .seed (cnt_seed),
    .en   (cnt_en),
    .count(cnt_value)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      served_q <= 1'(REQ_EVEN);
      last_q   <= 1'(REQ_ODD);
      rem_q    <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      served_q <= served_d;
      last_q   <= last_d;
      rem_q    <= rem_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    winner     = pick_winner(req, last_q);
    winner_len = winner ? len1 : len0;
    cnt_seed   = winner ? WIDTH'(ODD_SEED) : WIDTH'(EVEN_SEED);
    state_d    = state_q;
    served_d   = served_q;
    last_d     = last_q;
    rem_d      = rem_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;
    abort_d    = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_d  = ST_RUN;
          served_d = winner;
          gnt_d    = winner ? 2'b10 : 2'b01;
          rem_d    = (winner_len == '0) ? LEN_W'(1) : winner_len;
          cnt_load = 1'b1;
        end
      end
      ST_RUN: begin
        // A dropped request wins over completion: the shown beat is not consumed.
        if (!req[served_q]) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
          abort_d = 1'b1;
          last_d  = served_q;
        end else if (rem_q == LEN_W'(1)) begin
          state_d          = ST_IDLE;
          gnt_d            = 2'b00;
          done_d[served_q] = 1'b1;
          last_d           = served_q;
        end else begin
          cnt_en = 1'b1;
          rem_d  = rem_q - LEN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_comb begin
    out_valid = (state_q == ST_RUN);
    out_last  = (state_q == ST_RUN) && (rem_q == LEN_W'(1));
  end

  assign gnt       = gnt_q;
  assign out_value = cnt_value;
  assign done      = done_q;
  assign abort     = abort_q;

endmodule

// File: tb/tb_parity_burst_arbiter.sv
// Directed bench for parity_burst_arbiter: a burst-level reference model is
// compared every cycle, and literal beat lists pin the model.
module tb_parity_burst_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [1:0] gnt;
  logic       out_valid;
  logic [3:0] out_value;
  logic       out_last;
  logic [1:0] done;
  logic       abort;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  parity_burst_arbiter #(.WIDTH(4), .LEN_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .len0     (len0),
    .len1     (len1),
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_value(out_value),
    .out_last (out_last),
    .done     (done),
    .abort    (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Burst-level model: which requester is being served, which beat of how many.
  bit       m_ready = 0;
  bit       m_busy;
  int       m_who;
  int       m_idx;
  int       m_len;
  int       m_last;
  int       m_hold;
  bit [1:0] m_done;
  bit       m_abort;

  function automatic int m_beat();
    return (m_who + 2 * m_idx) % 16;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_ready = 1;
      m_busy  = 0;
      m_done  = 0;
      m_abort = 0;
      m_last  = 1;
      m_hold  = 0;
      m_who   = 0;
      m_idx   = 0;
      m_len   = 1;
    end else if (m_ready) begin
      m_done  = 0;
      m_abort = 0;
      if (m_busy) begin
        if (!req[m_who]) begin
          m_abort = 1;
          m_busy  = 0;
          m_last  = m_who;
          m_hold  = m_beat();
        end else if (m_idx == m_len - 1) begin
          m_done[m_who] = 1;
          m_busy = 0;
          m_last = m_who;
          m_hold = m_beat();
        end else begin
          m_idx++;
        end
      end else if (req != 2'b00) begin
        m_who  = (req == 2'b11) ? 1 - m_last : ((req == 2'b10) ? 1 : 0);
        m_len  = (m_who == 1) ? int'(len1) : int'(len0);
        if (m_len == 0) m_len = 1;
        m_idx  = 0;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      logic [10:0] act_v;
      logic [10:0] exp_v;
      logic [1:0]  e_gnt;
      logic [3:0]  e_val;
      e_gnt = m_busy ? ((m_who == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_val = m_busy ? 4'(m_beat()) : 4'(m_hold);
      exp_v = {e_gnt, m_busy, e_val, (m_busy && m_idx == m_len - 1), m_done, m_abort};
      act_v = {gnt, out_valid, out_value, out_last, done, abort};
      check("model {gnt,valid,value,last,done,abort}", 32'(act_v), 32'(exp_v));
    end
  end

  // Waits for the first beat, checks exp_q beat by beat, then the done cycle.
  task automatic run_burst(input string name, input logic [1:0] exp_gnt, input logic [1:0] exp_done);
    bit seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check({name, " first beat seen"}, 32'(seen), 32'd1);
    if (seen) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        check({name, " value"}, 32'(out_value), 32'(exp_q[i]));
        check({name, " last"}, 32'(out_last), 32'(i == exp_q.size() - 1));
        check({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
      end
      @(negedge clk);
      check({name, " done"}, 32'(done), 32'(exp_done));
      check({name, " idle after"}, 32'({gnt, out_valid, abort}), 32'd0);
    end
  endtask

  initial begin
    rst  = 1'b0;
    req  = 2'b11;
    len0 = 4'd1;
    len1 = 4'd1;
    repeat (2) @(negedge clk);
    check("reset outputs", 32'({gnt, out_valid, out_value, out_last, done, abort}), 32'd0);
    rst = 1'b1;
    exp_q = '{0};
    run_burst("first tie", 2'b01, 2'b01);
    req = 2'b00;

    len0 = 4'd4;
    req  = 2'b01;
    exp_q = '{0, 2, 4, 6};
    run_burst("even len4", 2'b01, 2'b01);
    req = 2'b00;

    len1 = 4'd3;
    req  = 2'b10;
    exp_q = '{1, 3, 5};
    run_burst("odd len3", 2'b10, 2'b10);
    req = 2'b00;

    len1 = 4'd0;
    req  = 2'b10;
    exp_q = '{1};
    run_burst("odd len0", 2'b10, 2'b10);
    req = 2'b00;

    len0 = 4'd2;
    len1 = 4'd2;
    req  = 2'b11;
    exp_q = '{0, 2};
    run_burst("rr first", 2'b01, 2'b01);
    exp_q = '{1, 3};
    run_burst("rr second", 2'b10, 2'b10);
    exp_q = '{0, 2};
    run_burst("rr third", 2'b01, 2'b01);
    req = 2'b00;

    len0 = 4'd10;
    req  = 2'b01;
    exp_q = '{0, 2, 4, 6, 8, 10, 12, 14, 0, 2};
    run_burst("wrap even", 2'b01, 2'b01);
    req = 2'b00;

    len1 = 4'd9;
    req  = 2'b10;
    exp_q = '{1, 3, 5, 7, 9, 11, 13, 15, 1};
    run_burst("wrap odd", 2'b10, 2'b10);
    req = 2'b00;

    len0 = 4'd5;
    len1 = 4'd2;
    req  = 2'b01;
    begin
      bit seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          seen = 1;
          break;
        end
      end
      check("abort first beat seen", 32'(seen), 32'd1);
      check("abort beat0", 32'(out_value), 32'd0);
      @(negedge clk);
      check("abort beat1", 32'(out_value), 32'd2);
      req = 2'b11;
      @(negedge clk);
      check("abort beat2", 32'(out_value), 32'd4);
      req = 2'b10;
      @(negedge clk);
      check("abort pulse", 32'(abort), 32'd1);
      check("abort no done", 32'(done), 32'd0);
      check("abort idle", 32'({gnt, out_valid}), 32'd0);
      check("abort value held", 32'(out_value), 32'd4);
    end
    exp_q = '{1, 3};
    run_burst("after abort", 2'b10, 2'b10);
    req = 2'b00;

    len1 = 4'd5;
    req  = 2'b10;
    begin
      bit seen = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          seen = 1;
          break;
        end
      end
      check("midreset first beat seen", 32'(seen), 32'd1);
      @(negedge clk);
      check("midreset beat1", 32'(out_value), 32'd3);
      rst = 1'b0;
      req = 2'b00;
      @(negedge clk);
      check("midreset outputs", 32'({gnt, out_valid, out_value, out_last, done, abort}), 32'd0);
      @(negedge clk);
      check("midreset no pulse", 32'({done, abort}), 32'd0);
      rst = 1'b1;
    end
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
